// File: rtl/snax_dimc_shell_pkg.sv
// rtl/snax_dimc_shell_pkg.sv - shared constants and types for the DIMC stream shell
// Purpose: CSR offsets (relative to the end of the CFG bank), STATUS bit
// positions and the run-control state encoding.
package snax_dimc_shell_pkg;

  // CSR word offsets, added to NumCfgRegs to form the absolute address.
  localparam int unsigned CSR_OFS_TARGET = 0;
  localparam int unsigned CSR_OFS_CTRL   = 1;
  localparam int unsigned CSR_OFS_STATUS = 2;
  localparam int unsigned CSR_OFS_CYCLES = 3;
  localparam int unsigned CSR_OFS_BEATS  = 4;

  // STATUS register bit positions.
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/snax_dimc_shell_fifo.sv
// rtl/snax_dimc_shell_fifo.sv - registered valid/ready FIFO used on every shell channel
// Purpose: elastic buffer of Depth entries (power of two, >= 2).
// Ports:
//   clk_i, rst                 clock, asynchronous active-high reset
//   in_data_i/valid_i/ready_o  push side; ready = !full || pop
//   out_data_o/valid_o/ready_i pop side; valid = !empty, data is the registered head
module snax_dimc_shell_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop, full;

  assign full        = (count_q == CntW'(Depth));
  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  // A pop in the same cycle frees the slot the push is about to use.
  assign in_ready_o  = !full || pop;
  assign push        = in_valid_i & in_ready_o;
  assign out_data_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/snax_dimc_stream_shell.sv
// rtl/snax_dimc_stream_shell.sv - DIMC shell: stream FIFOs, CSR front-end, run control
// Purpose: buffers NumInStreams input streams and one output stream around the
// DIMC core, exposes CFG/TARGET/CTRL/STATUS/CYCLES/BEATS CSRs, and runs an
// IDLE/RUN FSM that pulses core_start_o and counts accepted output beats.
// Ports:
//   clk_i, rst                         clock, asynchronous active-high reset
//   stream2acc_*                       input streams (channel k at bits k*InDataWidth)
//   acc2stream_*                       output stream
//   csr_req_* / csr_rsp_*              CSR request/response handshakes
//   core_in_* / core_out_*             core-side stream interfaces
//   core_cfg_o, core_start_o           config words and one-cycle start pulse
module snax_dimc_stream_shell
  import snax_dimc_shell_pkg::*;
#(
  parameter int unsigned NumInStreams = 4,
  parameter int unsigned InDataWidth  = 512,
  parameter int unsigned OutDataWidth = 512,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned NumCfgRegs   = 4,
  parameter int unsigned CsrAddrWidth = 32,
  parameter int unsigned CsrDataWidth = 32
) (
  input  logic                                clk_i,
  input  logic                                rst,
  input  logic [NumInStreams*InDataWidth-1:0] stream2acc_data_i,
  input  logic [NumInStreams-1:0]             stream2acc_valid_i,
  output logic [NumInStreams-1:0]             stream2acc_ready_o,
  output logic [OutDataWidth-1:0]             acc2stream_data_o,
  output logic                                acc2stream_valid_o,
  input  logic                                acc2stream_ready_i,
  input  logic [CsrAddrWidth-1:0]             csr_req_addr_i,
  input  logic [CsrDataWidth-1:0]             csr_req_data_i,
  input  logic                                csr_req_write_i,
  input  logic                                csr_req_valid_i,
  output logic                                csr_req_ready_o,
  output logic [CsrDataWidth-1:0]             csr_rsp_data_o,
  output logic                                csr_rsp_valid_o,
  input  logic                                csr_rsp_ready_i,
  output logic [NumInStreams*InDataWidth-1:0] core_in_data_o,
  output logic [NumInStreams-1:0]             core_in_valid_o,
  input  logic [NumInStreams-1:0]             core_in_ready_i,
  input  logic [OutDataWidth-1:0]             core_out_data_i,
  input  logic                                core_out_valid_i,
  output logic                                core_out_ready_o,
  output logic [NumCfgRegs*CsrDataWidth-1:0]  core_cfg_o,
  output logic                                core_start_o
);

  localparam int unsigned AddrTarget = NumCfgRegs + CSR_OFS_TARGET;
  localparam int unsigned AddrCtrl   = NumCfgRegs + CSR_OFS_CTRL;
  localparam int unsigned AddrStatus = NumCfgRegs + CSR_OFS_STATUS;
  localparam int unsigned AddrCycles = NumCfgRegs + CSR_OFS_CYCLES;
  localparam int unsigned AddrBeats  = NumCfgRegs + CSR_OFS_BEATS;

  state_e                  state_q, state_d;
  logic [CsrDataWidth-1:0] cfg_q [NumCfgRegs];
  logic [CsrDataWidth-1:0] target_q;
  logic [CsrDataWidth-1:0] cycles_q, cycles_d;
  logic [CsrDataWidth-1:0] beats_q, beats_d;
  logic                    done_q, done_d;
  logic                    start_q;
  logic                    rsp_valid_q;
  logic [CsrDataWidth-1:0] rsp_data_q, rd_data;
  logic                    run, wr_fire, rd_fire, start_go, beat_fire;
  logic [NumInStreams-1:0] fifo_valid;

  assign run             = (state_q == ST_RUN);
  assign csr_req_ready_o = !rsp_valid_q || csr_rsp_ready_i;
  assign wr_fire         = csr_req_valid_i && csr_req_ready_o && csr_req_write_i;
  assign rd_fire         = csr_req_valid_i && csr_req_ready_o && !csr_req_write_i;
  assign start_go        = wr_fire && (csr_req_addr_i == CsrAddrWidth'(AddrCtrl)) &&
                           csr_req_data_i[0] && !run && (target_q != '0);
  assign beat_fire       = run && acc2stream_valid_o && acc2stream_ready_i;
  assign csr_rsp_valid_o = rsp_valid_q;
  assign csr_rsp_data_o  = rsp_data_q;
  assign core_start_o    = start_q;

  // Run-control next state; busy is simply state==RUN.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    beats_d  = beats_q;
    done_d   = done_q;
    if (start_go) begin
      state_d  = ST_RUN;
      cycles_d = '0;
      beats_d  = '0;
      done_d   = 1'b0;
    end else if (run) begin
      cycles_d = cycles_q + CsrDataWidth'(1);
      if (beat_fire) begin
        beats_d = beats_q + CsrDataWidth'(1);
        if (beats_d == target_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NumCfgRegs; k++) begin
      if (csr_req_addr_i == CsrAddrWidth'(k)) rd_data = cfg_q[k];
    end
    if (csr_req_addr_i == CsrAddrWidth'(AddrTarget)) rd_data = target_q;
    if (csr_req_addr_i == CsrAddrWidth'(AddrStatus)) begin
      rd_data[STATUS_BUSY_BIT] = run;
      rd_data[STATUS_DONE_BIT] = done_q;
    end
    if (csr_req_addr_i == CsrAddrWidth'(AddrCycles)) rd_data = cycles_q;
    if (csr_req_addr_i == CsrAddrWidth'(AddrBeats))  rd_data = beats_q;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      cycles_q    <= '0;
      beats_q     <= '0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      for (int unsigned k = 0; k < NumCfgRegs; k++) cfg_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      beats_q  <= beats_d;
      done_q   <= done_d;
      start_q  <= start_go;
      // Config writes are dropped while a run is active but still accepted.
      if (wr_fire && !run) begin
        for (int unsigned k = 0; k < NumCfgRegs; k++) begin
          if (csr_req_addr_i == CsrAddrWidth'(k)) cfg_q[k] <= csr_req_data_i;
        end
        if (csr_req_addr_i == CsrAddrWidth'(AddrTarget)) target_q <= csr_req_data_i;
      end
      if (rd_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= rd_data;
      end else if (csr_rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NumCfgRegs; k++) begin : g_cfg
    assign core_cfg_o[k*CsrDataWidth +: CsrDataWidth] = cfg_q[k];
  end

  // Input channels fill in any state but only present to (and pop into) the core in RUN.
  for (genvar g = 0; g < NumInStreams; g++) begin : g_in
    snax_dimc_shell_fifo #(.Width(InDataWidth), .Depth(FifoDepth)) i_fifo (
      .clk_i      (clk_i),
      .rst        (rst),
      .in_data_i  (stream2acc_data_i[g*InDataWidth +: InDataWidth]),
      .in_valid_i (stream2acc_valid_i[g]),
      .in_ready_o (stream2acc_ready_o[g]),
      .out_data_o (core_in_data_o[g*InDataWidth +: InDataWidth]),
      .out_valid_o(fifo_valid[g]),
      .out_ready_i(core_in_ready_i[g] & run)
    );
    assign core_in_valid_o[g] = fifo_valid[g] & run;
  end

  snax_dimc_shell_fifo #(.Width(OutDataWidth), .Depth(FifoDepth)) i_out_fifo (
    .clk_i      (clk_i),
    .rst        (rst),
    .in_data_i  (core_out_data_i),
    .in_valid_i (core_out_valid_i),
    .in_ready_o (core_out_ready_o),
    .out_data_o (acc2stream_data_o),
    .out_valid_o(acc2stream_valid_o),
    .out_ready_i(acc2stream_ready_i)
  );

endmodule

// File: doc/snax_dimc_stream_shell.md
Name: snax_dimc_stream_shell

Overview:
Parametrised next-generation DIMC shell between the SNAX streamers/CSR manager and the DIMC compute core. It provides per-channel elastic buffering on N input streams and one output stream, a CSR front-end with config and performance registers, and a run-control FSM that issues start to the core and counts output beats to completion.

Parameters:
NumInStreams, 4, number of stream2acc input channels (1..8)
InDataWidth, 512, bits per input beat
OutDataWidth, 512, bits per output beat
FifoDepth, 4, entries per channel FIFO (power of two, >=2)
NumCfgRegs, 4, RW config words forwarded to the core
CsrAddrWidth, 32, CSR address width
CsrDataWidth, 32, CSR data width

Ports:
clk_i  in  1  clock
rst  in  1  asynchronous, active-high reset
stream2acc_data_i  in  NumInStreams*InDataWidth  input beats; channel k occupies bits [k*InDataWidth +: InDataWidth]
stream2acc_valid_i  in  NumInStreams  per-channel valid
stream2acc_ready_o  out  NumInStreams  per-channel ready (FIFO not full)
acc2stream_data_o  out  OutDataWidth  output beat
acc2stream_valid_o  out  1  output valid
acc2stream_ready_i  in  1  output ready
csr_req_addr_i  in  CsrAddrWidth  word address
csr_req_data_i  in  CsrDataWidth  write data
csr_req_write_i  in  1  1 = write, 0 = read
csr_req_valid_i  in  1  request valid
csr_req_ready_o  out  1  request ready
csr_rsp_data_o  out  CsrDataWidth  read data
csr_rsp_valid_o  out  1  response valid
csr_rsp_ready_i  in  1  response ready
core_in_data_o  out  NumInStreams*InDataWidth  FIFO heads to the core
core_in_valid_o  out  NumInStreams  FIFO not empty AND state==RUN
core_in_ready_i  in  NumInStreams  core pops
core_out_data_i  in  OutDataWidth  core result
core_out_valid_i  in  1  core result valid
core_out_ready_o  out  1  output FIFO not full
core_cfg_o  out  NumCfgRegs*CsrDataWidth  config words
core_start_o  out  1  one-cycle start pulse

Behaviour:
- Reset (asynchronous): all FIFOs empty; state IDLE; all CSRs 0. All valid outputs, core_start_o and csr_rsp_valid_o are 0. stream2acc_ready_o is all-ones and core_out_ready_o is 1 from the first edge after reset deasserts.
- FIFOs: each channel has an independent FIFO with FifoDepth entries.
  - Push on valid&ready; pop on valid&ready.
  - Simultaneous push and pop while full is allowed: ready = !full || pop.
  - Data reaches the FIFO output 1 cycle after push; there is no combinational input-to-output path.
  - Pointers wrap modulo FifoDepth. The count is $clog2(FifoDepth)+1 bits wide.
- Output FIFO sits between core_out and acc2stream, with the same rules as the input FIFOs. It drains in any state.
- CSR map (word addresses):
  - 0..NumCfgRegs-1: CFG, RW.
  - NumCfgRegs: TARGET, RW, number of output beats per run.
  - +1: CTRL, WO; writing bit0=1 requests start; reads return 0.
  - +2: STATUS, RO; bit0 = busy, bit1 = done-sticky (cleared by the next start).
  - +3: CYCLES, RO; cycles spent in RUN during the last/current run, wraps at 2^32.
  - +4: BEATS, RO; output beats accepted in the current run.
  - Out-of-range addresses read 0 and ignore writes.
- CSR handshake:
  - csr_req_ready_o = !csr_rsp_valid_o || csr_rsp_ready_i.
  - A write completes on acceptance and produces no response.
  - A read produces csr_rsp_valid_o the next cycle. It holds until csr_rsp_ready_i.
  - Writes to CFG/TARGET while busy are dropped; the request is still accepted.
- FSM states:
  - IDLE: a CTRL start write with TARGET!=0 goes to RUN next cycle. It pulses core_start_o for one cycle, clears CYCLES/BEATS/done, and sets busy. A start with TARGET==0 is ignored.
  - RUN: CYCLES increments every cycle. BEATS increments on each acc2stream handshake. When the handshake makes BEATS==TARGET, the next state is IDLE, busy=0 and done=1.
  - A start written while in RUN is ignored.
- Input stream beats are accepted into the FIFOs in any state, but are presented to the core only in RUN.
- Reset mid-run: immediate return to IDLE with everything cleared; in-flight FIFO data is discarded.

Decomposition:
- Package snax_dimc_shell_pkg: CSR offset constants (relative to NumCfgRegs), state enum {IDLE, RUN}, STATUS bit positions.
- One sub-module, snax_dimc_shell_fifo (parametrised width/depth). It is instantiated NumInStreams+1 times.

Test Plan:
- Reset then read STATUS -> rsp data 0. stream2acc_ready_o=4'hF, acc2stream_valid_o=0.
- Write CFG0=0xA5, TARGET=3, CTRL=1 -> core_start_o high exactly 1 cycle, STATUS=1, core_cfg_o[31:0]=0xA5.
- In RUN, core emits 3 beats 0x11/0x22/0x33 with acc2stream_ready_i toggling -> they arrive in order, BEATS=3, STATUS=2, state IDLE.
- Hold core_in_ready_i[1]=0 and push 5 beats on channel 1 (FifoDepth 4) -> ready_o[1] drops after 4. Release -> all 5 beats are delivered in order.
- Start with TARGET=0 -> no start pulse, STATUS=0. Write CFG1 during RUN -> CFG1 unchanged.
- Assert rst mid-run with 2 FIFO entries -> all valids 0 and STATUS=0 immediately. Entries lost.
